// File: rtl/mem_port_arbiter.sv
// Two-master arbiter for the unified RAM port: video-priority with a bounded streak,
// and a {valid, owner} tag pipeline that routes read data back after RD_LATENCY cycles.
module mem_port_arbiter #(
    parameter int unsigned AW             = 32,
    parameter int unsigned RD_LATENCY     = 1,
    parameter int unsigned MAX_VID_STREAK = 4
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_adr,
    input  logic [31:0]   cpu_wdata,
    input  logic [3:0]    cpu_be,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [31:0]   cpu_rdata,

    input  logic          vid_req,
    input  logic [AW-1:0] vid_adr,
    output logic          vid_gnt,
    output logic          vid_rvalid,
    output logic [31:0]   vid_rdata,

    output logic [AW-1:0] mem_adr,
    output logic [31:0]   mem_wdata,
    output logic          mem_we,
    output logic [3:0]    mem_be,
    input  logic [31:0]   mem_rdata
);

    if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
        $error("mem_port_arbiter: RD_LATENCY must be in 1..4");
    end
    if (MAX_VID_STREAK < 1 || MAX_VID_STREAK > 15) begin : g_bad_streak
        $error("mem_port_arbiter: MAX_VID_STREAK must be in 1..15");
    end

    localparam logic [3:0] StreakMax = 4'(MAX_VID_STREAK);

    typedef enum logic {
        OwnCpu = 1'b0,
        OwnVid = 1'b1
    } owner_e;

    logic [3:0]            streak_q, streak_d;
    logic [RD_LATENCY-1:0] tag_valid_q;
    owner_e                tag_owner_q [RD_LATENCY];

    logic   cpu_sel;
    logic   vid_sel;
    logic   push_valid;
    owner_e push_owner;
    logic   ret_valid;
    owner_e ret_owner;

    // Grants are held low during reset so nothing reaches the memory port.
    always_comb begin
        cpu_sel = 1'b0;
        vid_sel = 1'b0;
        if (!reset) begin
            if (vid_req && !(cpu_req && (streak_q == StreakMax))) begin
                vid_sel = 1'b1;
            end else if (cpu_req) begin
                cpu_sel = 1'b1;
            end
        end
    end

    always_comb begin
        cpu_gnt   = cpu_sel;
        vid_gnt   = vid_sel;
        mem_adr   = '0;
        mem_we    = 1'b0;
        mem_be    = 4'b0000;
        mem_wdata = 32'h0;
        if (cpu_sel) begin
            mem_adr   = cpu_adr;
            mem_we    = cpu_we;
            mem_be    = cpu_be;
            mem_wdata = cpu_wdata;
        end else if (vid_sel) begin
            mem_adr   = vid_adr;
            mem_be    = 4'b1111;
        end
    end

    always_comb begin
        streak_d = streak_q;
        if (vid_sel && cpu_req) begin
            if (streak_q != StreakMax) begin
                streak_d = streak_q + 4'd1;
            end
        end else if (cpu_sel || !cpu_req) begin
            streak_d = 4'd0;
        end
    end

    always_comb begin
        push_valid = vid_sel || (cpu_sel && !cpu_we);
        push_owner = vid_sel ? OwnVid : OwnCpu;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            streak_q    <= 4'd0;
            tag_valid_q <= '0;
            for (int unsigned i = 0; i < RD_LATENCY; i++) begin
                tag_owner_q[i] <= OwnCpu;
            end
        end else begin
            streak_q       <= streak_d;
            tag_valid_q[0] <= push_valid;
            tag_owner_q[0] <= push_owner;
            for (int unsigned i = 1; i < RD_LATENCY; i++) begin
                tag_valid_q[i] <= tag_valid_q[i-1];
                tag_owner_q[i] <= tag_owner_q[i-1];
            end
        end
    end

    always_comb begin
        ret_valid  = tag_valid_q[RD_LATENCY-1];
        ret_owner  = tag_owner_q[RD_LATENCY-1];
        cpu_rvalid = ret_valid && (ret_owner == OwnCpu);
        vid_rvalid = ret_valid && (ret_owner == OwnVid);
        cpu_rdata  = cpu_rvalid ? mem_rdata : 32'h0;
        vid_rdata  = vid_rvalid ? mem_rdata : 32'h0;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: two arbiters (read latency 1 and 3) share one set of requesters;
// a scoreboard queue per instance checks every read return for owner, cycle and data.
module tb_mem_port_arbiter;

    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_req, cpu_we, vid_req;
    logic [AW-1:0] cpu_adr, vid_adr;
    logic [31:0]   cpu_wdata;
    logic [3:0]    cpu_be;

    logic          cpu_gnt    [2];
    logic          vid_gnt    [2];
    logic          cpu_rvalid [2];
    logic          vid_rvalid [2];
    logic [31:0]   cpu_rdata  [2];
    logic [31:0]   vid_rdata  [2];
    logic [AW-1:0] mem_adr    [2];
    logic [31:0]   mem_wdata  [2];
    logic          mem_we     [2];
    logic [3:0]    mem_be     [2];
    logic [31:0]   mem_rdata  [2];
    logic [31:0]   pipe3      [3];

    typedef struct {
        int          due;
        bit          vid;
        logic [31:0] data;
    } ret_t;

    ret_t sb_q [2][$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_port_arbiter #(.AW(AW), .RD_LATENCY(1), .MAX_VID_STREAK(4)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata),
        .cpu_be(cpu_be), .cpu_gnt(cpu_gnt[0]), .cpu_rvalid(cpu_rvalid[0]),
        .cpu_rdata(cpu_rdata[0]), .vid_req(vid_req), .vid_adr(vid_adr),
        .vid_gnt(vid_gnt[0]), .vid_rvalid(vid_rvalid[0]), .vid_rdata(vid_rdata[0]),
        .mem_adr(mem_adr[0]), .mem_wdata(mem_wdata[0]), .mem_we(mem_we[0]),
        .mem_be(mem_be[0]), .mem_rdata(mem_rdata[0])
    );

    mem_port_arbiter #(.AW(AW), .RD_LATENCY(3), .MAX_VID_STREAK(4)) dut3 (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata),
        .cpu_be(cpu_be), .cpu_gnt(cpu_gnt[1]), .cpu_rvalid(cpu_rvalid[1]),
        .cpu_rdata(cpu_rdata[1]), .vid_req(vid_req), .vid_adr(vid_adr),
        .vid_gnt(vid_gnt[1]), .vid_rvalid(vid_rvalid[1]), .vid_rdata(vid_rdata[1]),
        .mem_adr(mem_adr[1]), .mem_wdata(mem_wdata[1]), .mem_we(mem_we[1]),
        .mem_be(mem_be[1]), .mem_rdata(mem_rdata[1])
    );

    function automatic logic [31:0] mem_word(input logic [AW-1:0] adr);
        return (adr * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Read-only memory model with fixed latency per instance.
    always @(posedge clk) begin
        mem_rdata[0] <= mem_word(mem_adr[0]);
        pipe3[0]     <= mem_word(mem_adr[1]);
        pipe3[1]     <= pipe3[0];
        pipe3[2]     <= pipe3[1];
    end
    assign mem_rdata[1] = pipe3[2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic chk_port(input string tag, input int i, input logic cg, input logic vg,
                            input logic [31:0] adr, input logic we, input logic [3:0] be,
                            input logic [31:0] wd);
        chk({tag, "_cpu_gnt"}, cpu_gnt[i], cg);
        chk({tag, "_vid_gnt"}, vid_gnt[i], vg);
        chk({tag, "_mem_adr"}, mem_adr[i], adr);
        chk({tag, "_mem_we"}, mem_we[i], we);
        chk({tag, "_mem_be"}, mem_be[i], be);
        chk({tag, "_mem_wdata"}, mem_wdata[i], wd);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: pop/compare returns, then push newly granted reads.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                sb_q[i].delete();
                chk_port("in_reset", i, 1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
                chk("in_reset_cpu_rvalid", cpu_rvalid[i], 1'b0);
                chk("in_reset_vid_rvalid", vid_rvalid[i], 1'b0);
            end else begin
                logic        exp_c, exp_v;
                logic [31:0] exp_d;
                exp_c = 1'b0;
                exp_v = 1'b0;
                exp_d = 32'h0;
                if (sb_q[i].size() > 0 && sb_q[i][0].due == cyc) begin
                    exp_c = !sb_q[i][0].vid;
                    exp_v = sb_q[i][0].vid;
                    exp_d = sb_q[i][0].data;
                    void'(sb_q[i].pop_front());
                end
                chk("cpu_rvalid", cpu_rvalid[i], exp_c);
                chk("vid_rvalid", vid_rvalid[i], exp_v);
                chk("cpu_rdata", cpu_rdata[i], exp_c ? exp_d : 32'h0);
                chk("vid_rdata", vid_rdata[i], exp_v ? exp_d : 32'h0);
                if (cpu_gnt[i] || vid_gnt[i]) begin
                    chk("one_grant", {cpu_gnt[i], vid_gnt[i]} != 2'b11, 1'b1);
                end
                if (vid_gnt[i]) begin
                    sb_q[i].push_back('{due: cyc + (i == 0 ? 1 : 3), vid: 1'b1,
                                        data: mem_word(vid_adr)});
                end else if (cpu_gnt[i] && !cpu_we) begin
                    sb_q[i].push_back('{due: cyc + (i == 0 ? 1 : 3), vid: 1'b0,
                                        data: mem_word(cpu_adr)});
                end
            end
        end
    end

    initial begin
        logic cg, vg;
        reset = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_adr = '0; cpu_wdata = '0; cpu_be = '0;
        vid_req = 1'b0; vid_adr = '0;
        repeat (2) step();
        // Requests during reset must not leak onto the port.
        cpu_req = 1'b1; vid_req = 1'b1; cpu_we = 1'b1; cpu_adr = 32'h40;
        cpu_wdata = 32'hDEAD_BEEF; cpu_be = 4'hF; vid_adr = 32'h80;
        repeat (3) step();
        cpu_req = 1'b0; vid_req = 1'b0; cpu_we = 1'b0;
        repeat (5) step();
        reset = 1'b0;

        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) chk_port("idle", i, 1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
            step();
        end

        // Core read at 0x104.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 32'h104; cpu_be = 4'hF; cpu_wdata = 32'h0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) chk_port("cpu_rd", i, 1'b1, 1'b0, 32'h104, 1'b0, 4'hF, 32'h0);
        step();
        cpu_req = 1'b0;
        repeat (4) step();

        // Core byte write at 0x203.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_adr = 32'h203; cpu_be = 4'b1000;
        cpu_wdata = 32'hAB00_0000;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk_port("cpu_wr", i, 1'b1, 1'b0, 32'h203, 1'b1, 4'b1000, 32'hAB00_0000);
        end
        step();
        cpu_req = 1'b0; cpu_we = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) chk_port("after_wr", i, 1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        repeat (4) step();

        // Continuous contention: V,V,V,V,C repeating.
        cpu_we = 1'b0; cpu_be = 4'hF; cpu_adr = 32'h1000; vid_adr = 32'h8000;
        cpu_req = 1'b1; vid_req = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                chk("streak_vid_gnt", vid_gnt[i], (k % 5) != 4);
                chk("streak_cpu_gnt", cpu_gnt[i], (k % 5) == 4);
            end
            vg = vid_gnt[0];
            cg = cpu_gnt[0];
            step();
            if (vg) vid_adr = vid_adr + 32'd4;
            if (cg) cpu_adr = cpu_adr + 32'd4;
        end
        cpu_req = 1'b0; vid_req = 1'b0;
        repeat (5) step();

        // Alternating single-requester reads, V at 0x400 and C at 0x010.
        for (int k = 0; k < 8; k++) begin
            vid_req = (k % 2) == 0;
            cpu_req = (k % 2) == 1;
            vid_adr = 32'h400;
            cpu_adr = 32'h010;
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                chk("alt_vid_gnt", vid_gnt[i], (k % 2) == 0);
                chk("alt_cpu_gnt", cpu_gnt[i], (k % 2) == 1);
            end
            step();
        end
        cpu_req = 1'b0; vid_req = 1'b0;
        repeat (5) step();

        // Build a full streak, then reset with reads in flight.
        cpu_adr = 32'h2000; vid_adr = 32'h9000;
        cpu_req = 1'b1; vid_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) chk("pre_rst_vid_gnt", vid_gnt[i], 1'b1);
            step();
            vid_adr = vid_adr + 32'd4;
        end
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("post_rst_vid_gnt", vid_gnt[i], 1'b1);
            chk("post_rst_cpu_gnt", cpu_gnt[i], 1'b0);
        end
        step();
        vid_req = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) chk("post_rst_cpu_gnt2", cpu_gnt[i], 1'b1);
        step();
        cpu_req = 1'b0;
        repeat (6) step();

        chk("sb_drained_lat1", sb_q[0].size(), 0);
        chk("sb_drained_lat3", sb_q[1].size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
